// File: rtl/rsa_modexp_ctrl_pkg.sv
// Shared types for the RSA modular-exponentiation controller and the
// Montgomery multiplier wrapper it drives.
package rsa_modexp_ctrl_pkg;

    // Controller sequencing states.
    typedef enum logic [3:0] {
        IDLE,
        BIT,
        MUL_REQ,
        MUL_WAIT,
        SQR_CHK,
        SQR_REQ,
        SQR_WAIT,
        FIX_REQ,
        FIX_WAIT,
        DONE
    } modexp_state_t;

    // Operand width of the shared multiplier wrapper's request bundle.
    localparam int unsigned MONT_WIDTH = 256;

    // One multiply request as seen by the multiplier wrapper.
    typedef struct packed {
        logic [MONT_WIDTH-1:0] a;
        logic [MONT_WIDTH-1:0] b;
        logic [MONT_WIDTH-1:0] modulus;
    } mont_req_t;

    // States that hold a multiply request open towards the multiplier.
    function automatic logic is_req_state(input modexp_state_t s);
        return (s == MUL_REQ) || (s == SQR_REQ) || (s == FIX_REQ);
    endfunction

    // States that wait for the multiplier's product.
    function automatic logic is_wait_state(input modexp_state_t s);
        return (s == MUL_WAIT) || (s == SQR_WAIT) || (s == FIX_WAIT);
    endfunction

endpackage

// File: rtl/rsa_modexp_ctrl.sv
// Right-to-left square-and-multiply sequencer for one external Montgomery
// multiplier. Computes M^E mod N from Montgomery-domain inputs and leaves the
// Montgomery domain with a final multiply by 1.
module rsa_modexp_ctrl
    import rsa_modexp_ctrl_pkg::*;
#(
    parameter int unsigned MOD_WIDTH = 256,
    parameter int unsigned KEY_WIDTH = 256
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 i_valid,
    output logic                 i_ready,
    input  logic [MOD_WIDTH-1:0] i_msg,
    input  logic [MOD_WIDTH-1:0] i_one,
    input  logic [KEY_WIDTH-1:0] i_key,
    input  logic [MOD_WIDTH-1:0] i_modulus,

    output logic                 o_valid,
    input  logic                 o_ready,
    output logic [MOD_WIDTH-1:0] o_out,

    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [MOD_WIDTH-1:0] m_a,
    output logic [MOD_WIDTH-1:0] m_b,
    output logic [MOD_WIDTH-1:0] m_modulus,

    input  logic                 r_valid,
    output logic                 r_ready,
    input  logic [MOD_WIDTH-1:0] r_out
);

    localparam int unsigned CNT_W = $clog2(KEY_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(KEY_WIDTH - 1);

    modexp_state_t        state,     state_d;
    logic [MOD_WIDTH-1:0] acc,       acc_d;
    logic [MOD_WIDTH-1:0] base,      base_d;
    logic [KEY_WIDTH-1:0] key_sh,    key_sh_d;
    logic [CNT_W-1:0]     bit_cnt,   bit_cnt_d;
    logic [MOD_WIDTH-1:0] o_out_d;
    logic [MOD_WIDTH-1:0] m_a_d;
    logic [MOD_WIDTH-1:0] m_b_d;
    logic [MOD_WIDTH-1:0] m_modulus_d;

    // Handshake flags are pure decodes of the registered state, so they
    // stay high until the transfer completes and cannot glitch on inputs.
    assign i_ready = (state == IDLE);
    assign o_valid = (state == DONE);
    assign m_valid = is_req_state(state);
    assign r_ready = is_wait_state(state);

    // Next-state and next-register computation.
    always_comb begin
        // NOTE: every target gets its hold value first, so no path through
        // the case statement can leave one unassigned and infer a latch.
        state_d     = state;
        acc_d       = acc;
        base_d      = base;
        key_sh_d    = key_sh;
        bit_cnt_d   = bit_cnt;
        o_out_d     = o_out;
        m_a_d       = m_a;
        m_b_d       = m_b;
        m_modulus_d = m_modulus;

        unique case (state)
            IDLE: begin
                if (i_valid) begin
                    acc_d       = i_one;
                    base_d      = i_msg;
                    key_sh_d    = i_key;
                    m_modulus_d = i_modulus;
                    bit_cnt_d   = '0;
                    state_d     = BIT;
                end
            end
            BIT: begin
                if (key_sh[0]) begin
                    // Operands are registered on entry so they stay stable
                    // for the whole request phase.
                    m_a_d   = acc;
                    m_b_d   = base;
                    state_d = MUL_REQ;
                end else begin
                    state_d = SQR_CHK;
                end
            end
            MUL_REQ: begin
                if (m_ready) state_d = MUL_WAIT;
            end
            MUL_WAIT: begin
                if (r_valid) begin
                    acc_d   = r_out;
                    state_d = SQR_CHK;
                end
            end
            SQR_CHK: begin
                if (bit_cnt == LAST_BIT) begin
                    // Squaring after the top bit would be wasted work.
                    m_a_d   = acc;
                    m_b_d   = MOD_WIDTH'(1);
                    state_d = FIX_REQ;
                end else begin
                    m_a_d   = base;
                    m_b_d   = base;
                    state_d = SQR_REQ;
                end
            end
            SQR_REQ: begin
                if (m_ready) state_d = SQR_WAIT;
            end
            SQR_WAIT: begin
                if (r_valid) begin
                    base_d    = r_out;
                    key_sh_d  = key_sh >> 1;
                    bit_cnt_d = bit_cnt + 1'b1;
                    state_d   = BIT;
                end
            end
            FIX_REQ: begin
                if (m_ready) state_d = FIX_WAIT;
            end
            FIX_WAIT: begin
                if (r_valid) begin
                    o_out_d = r_out;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (o_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: datapath registers are cleared too so a job aborted by
            // reset leaves no operand or result visible on the ports.
            state     <= IDLE;
            acc       <= '0;
            base      <= '0;
            key_sh    <= '0;
            bit_cnt   <= '0;
            o_out     <= '0;
            m_a       <= '0;
            m_b       <= '0;
            m_modulus <= '0;
        end else begin
            // NOTE: non-blocking assignments make every register update from
            // the same pre-edge values, independent of statement order.
            state     <= state_d;
            acc       <= acc_d;
            base      <= base_d;
            key_sh    <= key_sh_d;
            bit_cnt   <= bit_cnt_d;
            o_out     <= o_out_d;
            m_a       <= m_a_d;
            m_b       <= m_b_d;
            m_modulus <= m_modulus_d;
        end
    end

endmodule
